// File: rtl/game_round_sequencer.sv
// game_round_sequencer: runs NUM_ROUNDS reset/INIT/play rounds on one Game_State instance and tallies wins/losses.
// Defining SEQ_TIMEOUT_EN adds a per-round RUN watchdog (TIMEOUT cycles) and the sticky timeout_err flag.
module game_round_sequencer #(
    parameter int COUNTER_SIZE = 4,
    parameter int NUM_ROUNDS   = 8
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 512
`endif
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    start,
    input  logic [1:0]              cfg_control,
    input  logic [COUNTER_SIZE-1:0] cfg_value,
    output logic                    gs_reset,
    output logic [1:0]              control,
    output logic [COUNTER_SIZE-1:0] i_value,
    output logic                    INIT,
    input  logic [1:0]              who,
    input  logic                    gameover,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              win_rounds,
    output logic [3:0]              los_rounds,
    output logic                    timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    logic [2:0]              state_q, state_d;
    logic                    phase_q, phase_d;
    logic [3:0]              round_q, round_d;
    logic [3:0]              win_q, win_d;
    logic [3:0]              los_q, los_d;
    logic [1:0]              ctl_base_q, ctl_base_d;
    logic [COUNTER_SIZE-1:0] val_base_q, val_base_d;
    logic [1:0]              who_q, who_d;
    logic                    gameover_q;
    logic                    go_edge;
    logic                    accept;
    logic                    run_expire;
    logic                    timed_out_q;

    // A gameover already high when RUN starts has gameover_q=1 and is not an edge.
    assign go_edge = gameover & ~gameover_q;
    assign accept  = (state_q == S_IDLE) & start;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        win_d      = win_q;
        los_d      = los_q;
        ctl_base_d = ctl_base_q;
        val_base_d = val_base_q;
        who_d      = who_q;
        // phase toggles through the two-cycle RESET and LOAD windows
        phase_d    = ((state_q == S_RESET) || (state_q == S_LOAD)) ? ~phase_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    round_d    = '0;
                    win_d      = '0;
                    los_d      = '0;
                    ctl_base_d = cfg_control;
                    val_base_d = cfg_value;
                    state_d    = S_RESET;
                end
            end
            S_RESET: if (phase_q) state_d = S_LOAD;
            S_LOAD:  if (phase_q) state_d = S_RUN;
            S_RUN: begin
                if (go_edge) begin
                    who_d   = who;
                    state_d = S_RECORD;
                end else if (run_expire) begin
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                if (!timed_out_q) begin
                    if (who_q == 2'b10) win_d = win_q + 4'd1;
                    else                los_d = los_q + 4'd1;
                end
                round_d = round_q + 4'd1;
                state_d = (round_d == LAST_ROUND) ? S_DONE : S_RESET;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            round_q    <= '0;
            win_q      <= '0;
            los_q      <= '0;
            ctl_base_q <= '0;
            val_base_q <= '0;
            who_q      <= '0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            round_q    <= round_d;
            win_q      <= win_d;
            los_q      <= los_d;
            ctl_base_q <= ctl_base_d;
            val_base_q <= val_base_d;
            who_q      <= who_d;
            gameover_q <= gameover;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic          timed_out_d;
    logic          timeout_err_q, timeout_err_d;
    logic          expire_now;

    // A gameover edge in the final RUN cycle wins over the timeout.
    assign run_expire = (run_cnt_q == CW'(TIMEOUT - 1));
    assign expire_now = (state_q == S_RUN) & run_expire & ~go_edge;

    always_comb begin
        run_cnt_d     = (state_q == S_RUN) ? run_cnt_q + 1'b1 : '0;
        timed_out_d   = expire_now;
        timeout_err_d = accept ? 1'b0 : (timeout_err_q | expire_now);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            run_cnt_q     <= '0;
            timed_out_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            timed_out_q   <= timed_out_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign run_expire  = 1'b0;
    assign timed_out_q = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign gs_reset   = (state_q == S_IDLE) || (state_q == S_RESET) || (state_q == S_DONE);
    assign INIT       = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign control    = ctl_base_q + round_q[1:0];
    assign i_value    = val_base_q + COUNTER_SIZE'(round_q);
    assign win_rounds = win_q;
    assign los_rounds = los_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: table-driven sessions, hand corner cases, random sessions vs a round model.
module tb_game_round_sequencer;

    logic       clk;
    logic       rst_l;
    logic       start;
    logic [1:0] cfg_control;
    logic [3:0] cfg_value;
    logic       gs_reset;
    logic [1:0] control;
    logic [3:0] i_value;
    logic       INIT;
    logic [1:0] who;
    logic       gameover;
    logic       busy;
    logic       done;
    logic [3:0] win_rounds;
    logic [3:0] los_rounds;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    game_round_sequencer #(
        .COUNTER_SIZE(4),
        .NUM_ROUNDS(4)
`ifdef SEQ_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst_l(rst_l), .start(start),
        .cfg_control(cfg_control), .cfg_value(cfg_value),
        .gs_reset(gs_reset), .control(control), .i_value(i_value), .INIT(INIT),
        .who(who), .gameover(gameover), .busy(busy), .done(done),
        .win_rounds(win_rounds), .los_rounds(los_rounds), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] c;
        logic [3:0] v;
        logic [7:0] whos;
        int         exp_w;
        int         exp_l;
        bit         stale;
        bit         xstart;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gs_reset"}, gs_reset, 1);
        chk({tag, "_init"}, INIT, 0);
        chk({tag, "_control"}, control, 0);
        chk({tag, "_i_value"}, i_value, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_win"}, win_rounds, 0);
        chk({tag, "_los"}, los_rounds, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Reference model: round k plays control (c+k) mod 4 and value (v+k) mod 16; a win is who==2
    function automatic int model_ctl(input int c, input int k);
        return (c + k) % 4;
    endfunction

    function automatic int model_val(input int v, input int k);
        return (v + k) % 16;
    endfunction

    function automatic int count_wins(input logic [7:0] whos);
        int n = 0;
        for (int k = 0; k < 4; k++) if (whos[2*k +: 2] == 2'b10) n++;
        return n;
    endfunction

    // Drives one session starting at a negedge; abort_round >= 0 asserts rst_l in that round's RUN.
    task automatic run_session(input logic [1:0] c, input logic [3:0] v, input logic [7:0] whos,
                               input int exp_w, input int exp_l, input bit stale,
                               input bit xstart, input int abort_round);
        int w;
        int l;
        int hold;
        w = 0;
        l = 0;
        cfg_control = c;
        cfg_value   = v;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                chk("reset_gs", gs_reset, 1);
                chk("reset_init", INIT, 0);
                chk("reset_busy", busy, 1);
                chk("reset_done", done, 0);
                chk("reset_control", control, model_ctl(c, k));
                chk("reset_value", i_value, model_val(v, k));
                @(negedge clk);
            end
            for (int i = 0; i < 2; i++) begin
                chk("load_init", INIT, 1);
                chk("load_gs", gs_reset, 0);
                chk("load_control", control, model_ctl(c, k));
                chk("load_value", i_value, model_val(v, k));
                if (stale && i == 1) gameover = 1'b1;
                @(negedge clk);
            end
            if (k == abort_round) begin
                rst_l = 1'b0;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                rst_l    = 1'b1;
                gameover = 1'b0;
                @(negedge clk);
                return;
            end
            chk("run_init", INIT, 0);
            if (stale) begin
                for (int i = 0; i < 4; i++) begin
                    chk("stale_gs", gs_reset, 0);
                    chk("stale_win", win_rounds, w);
                    chk("stale_los", los_rounds, l);
                    @(negedge clk);
                end
                gameover = 1'b0;
                @(negedge clk);
            end
            if (xstart && k == 1) begin
                start       = 1'b1;
                cfg_control = c + 2'd1;
                cfg_value   = v + 4'd5;
                @(negedge clk);
                start = 1'b0;
                chk("xstart_busy", busy, 1);
            end
            hold = int'($urandom_range(0, 3));
            repeat (hold) begin
                chk("run_gs", gs_reset, 0);
                chk("run_control", control, model_ctl(c, k));
                chk("run_value", i_value, model_val(v, k));
                @(negedge clk);
            end
            who      = whos[2*k +: 2];
            gameover = 1'b1;
            @(negedge clk);
            gameover = 1'b0;
            who      = 2'($urandom);
            chk("record_gs", gs_reset, 0);
            chk("record_busy", busy, 1);
            chk("record_win_old", win_rounds, w);
            chk("record_los_old", los_rounds, l);
            if (whos[2*k +: 2] == 2'b10) w++;
            else                         l++;
            @(negedge clk);
            chk("tally_win", win_rounds, w);
            chk("tally_los", los_rounds, l);
            chk("next_gs", gs_reset, 1);
            chk("next_done", done, (k == 3) ? 1 : 0);
            if (k == 3) begin
                chk("done_busy", busy, 1);
                @(negedge clk);
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_gs", gs_reset, 1);
                chk("final_win", win_rounds, exp_w);
                chk("final_los", los_rounds, exp_l);
                chk("final_timeout_err", timeout_err, 0);
                @(negedge clk);
                chk("hold_win", win_rounds, exp_w);
                chk("hold_done", done, 0);
            end
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic run_timeout_session();
        cfg_control = 2'd1;
        cfg_value   = 4'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            for (int i = 1; i <= 17; i++) begin
                chk("to_run_gs", gs_reset, 0);
                @(negedge clk);
            end
            chk("to_end_gs", gs_reset, 1);
            chk("to_done", done, (k == 3) ? 1 : 0);
        end
        chk("to_err", timeout_err, 1);
        chk("to_win", win_rounds, 0);
        chk("to_los", los_rounds, 0);
        @(negedge clk);
        chk("to_idle_busy", busy, 0);
        chk("to_err_sticky", timeout_err, 1);
    endtask
`endif

    vec_t vecs[4];

    initial begin
        vecs[0] = '{c: 2'd2, v: 4'd14, whos: 8'b10_10_10_10, exp_w: 4, exp_l: 0, stale: 1'b0, xstart: 1'b0};
        vecs[1] = '{c: 2'd1, v: 4'd3,  whos: 8'b00_01_00_01, exp_w: 0, exp_l: 4, stale: 1'b0, xstart: 1'b0};
        vecs[2] = '{c: 2'd3, v: 4'd0,  whos: 8'b00_10_11_10, exp_w: 2, exp_l: 2, stale: 1'b0, xstart: 1'b0};
        vecs[3] = '{c: 2'd0, v: 4'd15, whos: 8'b10_10_10_11, exp_w: 3, exp_l: 1, stale: 1'b1, xstart: 1'b1};

        rst_l       = 1'b0;
        start       = 1'b0;
        cfg_control = 2'd0;
        cfg_value   = 4'd0;
        who         = 2'd0;
        gameover    = 1'b0;
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        for (int n = 0; n < 4; n++) begin
            $display("session table[%0d] control=%0d value=%0d", n, vecs[n].c, vecs[n].v);
            run_session(vecs[n].c, vecs[n].v, vecs[n].whos, vecs[n].exp_w, vecs[n].exp_l,
                        vecs[n].stale, vecs[n].xstart, -1);
        end

        $display("session abort during round 1");
        run_session(2'd0, 4'd0, 8'hAA, 0, 0, 1'b0, 1'b0, 1);
        $display("session restart after abort");
        run_session(2'd0, 4'd0, 8'h1B, count_wins(8'h1B), 4 - count_wins(8'h1B), 1'b0, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            logic [1:0] rc;
            logic [3:0] rv;
            logic [7:0] rw;
            rc = 2'($urandom);
            rv = 4'($urandom);
            rw = 8'($urandom);
            $display("session random[%0d] control=%0d value=%0d whos=%02h", n, rc, rv, rw);
            run_session(rc, rv, rw, count_wins(rw), 4 - count_wins(rw), 1'b0, 1'b0, -1);
        end

`ifdef SEQ_TIMEOUT_EN
        $display("session timeout");
        run_timeout_session();
        $display("session after timeout");
        run_session(2'd3, 4'd9, 8'h2A, count_wins(8'h2A), 4 - count_wins(8'h2A), 1'b0, 1'b0, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
